// File: rtl/vc_tdm_mux_sched.sv
// vc_tdm_mux_sched: fixed round-robin TDM scheduler sharing one val/rdy
// channel between p_nreqs requesters in separate security domains.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   en         scheduler enable; low parks the slot at requester 0
//   in_val     per-requester valid (bit i = requester i)
//   in_rdy     per-requester ready; only the slot owner is ever granted
//   out_val    downstream valid (owner's in_val, gated)
//   out_rdy    downstream ready
//   sel        current slot owner, drives the data mux select
//   slot_last  high in the final cycle of the current slot
//
// Optional feature macro: VC_TDM_GUARD_EN makes the last cycle of every
// slot a dead cycle so downstream pipelines settle between domains.

module vc_tdm_mux_sched #(
    parameter int p_nreqs       = 2,
    parameter int p_slot_cycles = 4,
    parameter int p_sel_nbits   = 1,
    parameter int p_cnt_nbits   = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic [p_nreqs-1:0]     in_val,
    output logic [p_nreqs-1:0]     in_rdy,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_sel_nbits-1:0] sel,
    output logic                   slot_last
);

    localparam logic [p_sel_nbits-1:0] LastOwner = p_sel_nbits'(p_nreqs - 1);
    localparam logic [p_cnt_nbits-1:0] LastCnt   = p_cnt_nbits'(p_slot_cycles - 1);
    localparam int                     ValW      = 2 ** p_sel_nbits;

    logic [p_sel_nbits-1:0] owner_q, owner_d;
    logic [p_cnt_nbits-1:0] cnt_q, cnt_d;
    logic                   at_last;
    logic                   guard;
    logic                   act;
    logic [ValW-1:0]        val_ext;

    assign at_last = (cnt_q == LastCnt);

`ifdef VC_TDM_GUARD_EN
    assign guard = at_last;
`else
    assign guard = 1'b0;
`endif

    // reset_n is folded in so every output reads 0 while reset is held,
    // even with en high and requests pending.
    assign act = reset_n & en & ~guard;

    // Pad in_val to a power of two so indexing by owner is always in range.
    always_comb begin
        val_ext = '0;
        val_ext[p_nreqs-1:0] = in_val;
    end

    assign sel       = owner_q;
    assign out_val   = act & val_ext[owner_q];
    assign slot_last = reset_n & en & at_last;

    // Grant depends on out_rdy only, never on in_val.
    always_comb begin
        in_rdy = '0;
        for (int i = 0; i < p_nreqs; i++) begin
            in_rdy[i] = act & out_rdy & (owner_q == p_sel_nbits'(i));
        end
    end

    // Slot timing ignores traffic entirely; disable wins over slot advance.
    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (!en) begin
            owner_d = '0;
            cnt_d   = '0;
        end else if (at_last) begin
            cnt_d   = '0;
            owner_d = (owner_q == LastOwner) ? '0
                                             : owner_q + p_sel_nbits'(1);
        end else begin
            cnt_d = cnt_q + p_cnt_nbits'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_vc_tdm_mux_sched.sv
// tb_vc_tdm_mux_sched: directed bench for the TDM scheduler, using a
// 2-requester and a 3-requester instance sharing clock and reset.

module tb_vc_tdm_mux_sched;

`ifdef VC_TDM_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int XPS = GUARD ? 3 : 4;

    logic       clk;
    logic       reset_n;
    logic       en2, en3;
    logic       out_rdy2, out_rdy3;
    logic [1:0] in_val2, in_rdy2;
    logic       out_val2, sel2, slot_last2;
    logic [2:0] in_val3, in_rdy3;
    logic       out_val3, slot_last3;
    logic [1:0] sel3;

    int checks;
    int failures;
    int x0, x1, xb;

    vc_tdm_mux_sched #(
        .p_nreqs(2), .p_slot_cycles(4), .p_sel_nbits(1), .p_cnt_nbits(2)
    ) u_dut2 (
        .clk(clk), .reset_n(reset_n), .en(en2),
        .in_val(in_val2), .in_rdy(in_rdy2),
        .out_val(out_val2), .out_rdy(out_rdy2),
        .sel(sel2), .slot_last(slot_last2)
    );

    vc_tdm_mux_sched #(
        .p_nreqs(3), .p_slot_cycles(4), .p_sel_nbits(2), .p_cnt_nbits(2)
    ) u_dut3 (
        .clk(clk), .reset_n(reset_n), .en(en3),
        .in_val(in_val3), .in_rdy(in_rdy3),
        .out_val(out_val3), .out_rdy(out_rdy3),
        .sel(sel3), .slot_last(slot_last3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    // Check dut2 at slot-relative cycle k (owner=(k/4)%2, cnt=k%4).
    task automatic check2(input string tag, input int k);
        int  own;
        bit  last;
        bit  a;
        #1;
        own  = (k / 4) % 2;
        last = (k % 4) == 3;
        a    = !(GUARD && last);
        chk({tag, "_sel"}, 8'(sel2), 8'(own));
        chk({tag, "_last"}, 8'(slot_last2), 8'(last));
        chk({tag, "_rdy"}, 8'(in_rdy2),
            (a && out_rdy2) ? 8'(1 << own) : 8'h0);
        chk({tag, "_val"}, 8'(out_val2), 8'(a && in_val2[own]));
        if (out_val2 && in_rdy2[sel2]) begin
            if (sel2) x1++;
            else x0++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        x0 = 0; x1 = 0; xb = 0;
        reset_n  = 1'b0;
        en2      = 1'b1;
        en3      = 1'b0;
        in_val2  = 2'b11;
        in_val3  = 3'b111;
        out_rdy2 = 1'b1;
        out_rdy3 = 1'b1;

        // Reset held with en high and all valid: outputs must read 0.
        #12;
        chk("rst_sel", 8'(sel2), 8'h0);
        chk("rst_rdy", 8'(in_rdy2), 8'h0);
        chk("rst_val", 8'(out_val2), 8'h0);
        chk("rst_last", 8'(slot_last2), 8'h0);
        chk("rst_sel3", 8'(sel3), 8'h0);
        @(posedge clk);
        #3 reset_n = 1'b1;

        // Full-demand round robin, two periods.
        for (int c = 0; c < 16; c++) begin
            if (c > 0) nxt();
            check2($sformatf("rr%0d", c), c);
            if (c == 7 || c == 15) begin
                chk("rr_xfer0", 8'(x0), 8'(XPS));
                chk("rr_xfer1", 8'(x1), 8'(XPS));
                x0 = 0; x1 = 0;
            end
        end

        // Isolation: only requester 1 asks; slot boundaries unchanged.
        for (int k = 0; k < 8; k++) begin
            nxt();
            in_val2 = 2'b10;
            check2($sformatf("iso%0d", k), k);
            if (k == 3) chk("iso_early", 8'(x1), 8'h0);
        end
        chk("iso_xfer0", 8'(x0), 8'h0);
        chk("iso_xfer1", 8'(x1), 8'(XPS));
        in_val2 = 2'b11;

        // Disable at cnt=2 of requester 1's slot.
        for (int k = 0; k < 6; k++) begin
            nxt();
            check2($sformatf("pre%0d", k), k);
        end
        nxt();
        en2 = 1'b0;
        #1;
        chk("dis_sel", 8'(sel2), 8'h1);
        chk("dis_val", 8'(out_val2), 8'h0);
        chk("dis_rdy", 8'(in_rdy2), 8'h0);
        chk("dis_last", 8'(slot_last2), 8'h0);
        nxt();
        chk("dis_sel0", 8'(sel2), 8'h0);
        nxt();
        en2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) nxt();
            check2($sformatf("rearm%0d", k), k);
        end

        // en falls in a slot_last cycle: disable wins, owner stays 0.
        nxt();
        chk("sim_sel", 8'(sel2), 8'h1);
        nxt();
        nxt();
        nxt();
        en2 = 1'b0;
        #1;
        chk("sim_last", 8'(slot_last2), 8'h0);
        chk("sim_sel1", 8'(sel2), 8'h1);
        nxt();
        chk("sim_owner", 8'(sel2), 8'h0);
        nxt();
        en2 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) nxt();
            check2($sformatf("run%0d", k), k);
        end

        // Reset pulse at cnt=1 of requester 1's slot, between clock edges.
        #1 reset_n = 1'b0;
        #1;
        chk("arst_sel", 8'(sel2), 8'h0);
        chk("arst_rdy", 8'(in_rdy2), 8'h0);
        chk("arst_val", 8'(out_val2), 8'h0);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) nxt();
            check2($sformatf("post%0d", k), k);
        end

        // Three requesters, backpressure in cycles 2-5, wrap to 0.
        for (int c = 0; c < 13; c++) begin
            int own;
            nxt();
            en3      = 1'b1;
            out_rdy3 = !(c >= 2 && c <= 5);
            #1;
            own = (c / 4) % 3;
            chk($sformatf("bp%0d_sel", c), 8'(sel3), 8'(own));
            chk($sformatf("bp%0d_val", c), 8'(out_val3),
                8'(!(GUARD && (c % 4) == 3)));
            chk($sformatf("bp%0d_rdy", c), 8'(in_rdy3),
                (out_rdy3 && !(GUARD && (c % 4) == 3)) ?
                8'(1 << own) : 8'h0);
            chk($sformatf("bp%0d_range", c), 8'(sel3 == 2'd3), 8'h0);
            if (c >= 2 && c <= 5 && out_val3 && in_rdy3 != 3'b000) xb++;
        end
        chk("bp_xfers", 8'(xb), 8'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vc_tdm_mux_sched.md
# vc_tdm_mux_sched

Time-division-multiplexed scheduler that shares a single downstream val/rdy channel between up to eight requesters from different security domains. It owns the select line of a vc_Mux2..vc_Mux8 data mux and gates the val/rdy handshake. Each requester gets a fixed, demand-independent slot in strict round-robin order, so no requester's traffic can change another's grant timing. It sits between the per-domain request queues and any shared resource port, such as a memory or cache request channel.

## Interface
- p_nreqs, 2: number of requesters; legal range 2..8.
- p_slot_cycles, 4: slot length in cycles; legal minimum 1, or 2 when VC_TDM_GUARD_EN is defined.
- p_sel_nbits, 1: select width; must equal clog2(p_nreqs), with a minimum of 1.
- p_cnt_nbits, 2: slot-counter width; must satisfy 2^p_cnt_nbits >= p_slot_cycles.
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  scheduler enable.
- in_val  input  p_nreqs  per-requester valid; bit i belongs to requester i.
- in_rdy  output  p_nreqs  per-requester ready.
- out_val  output  1  downstream valid.
- out_rdy  input  1  downstream ready.
- sel  output  p_sel_nbits  current slot owner; drives the data mux select.
- slot_last  output  1  high in the final cycle of the current slot.

## Operation
- State:
  - owner register (p_sel_nbits): current slot owner.
  - cnt register (p_cnt_nbits): cycle index within the current slot.
- Reset (reset_n = 0, asynchronous):
  - owner = 0, cnt = 0.
  - All outputs read 0: out_val = 0, in_rdy = 0, sel = 0, slot_last = 0.
- Slot advance, when en = 1:
  - If cnt == p_slot_cycles-1: cnt <= 0; owner <= owner+1, wrapping from p_nreqs-1 to 0.
  - Otherwise: cnt <= cnt+1.
- Disable, when en = 0:
  - Next edge sets cnt <= 0 and owner <= 0.
  - Outputs forced: out_val = 0, in_rdy = 0, slot_last = 0.
- Combinational outputs (act = en & ~guard):
  - sel = owner.
  - out_val = act & in_val[owner].
  - in_rdy[i] = act & out_rdy & (i == owner).
  - in_rdy for every non-owner is 0.
  - slot_last = en & (cnt == p_slot_cycles-1).
- Transfer: occurs in any cycle with in_val[owner] & in_rdy[owner], i.e. when out_val & out_rdy.
- Slot timing is independent of in_val and out_rdy:
  - An idle owner's slot is wasted.
  - Requests from non-owners are never granted early.
- in_rdy depends on out_rdy but never on in_val, so there is no combinational loop through upstream logic.
- Owner values >= p_nreqs are unreachable.

## Timing
- Latency: a grant is zero-cycle combinational, within the owner's slot.
- A slot starts in the cycle after slot_last.
- The first slot after reset release, or after en rises, belongs to requester 0, starting at that cycle.
- Full period is p_nreqs × p_slot_cycles cycles.
- A transfer in the slot_last cycle is legal when guard is off; the next cycle belongs to the new owner.
- Simultaneous en fall and slot_last: the disable behaviour wins (owner <= 0).
- Reset asserted mid-slot: the state clears immediately; any in-flight handshake in that cycle is void.
- Backpressure (out_rdy = 0): out_val still follows in_val[owner]; in_rdy = 0; the slot still advances.

## Configuration
- VC_TDM_GUARD_EN:
  - Defined: guard = (cnt == p_slot_cycles-1). The last cycle of every slot is a dead cycle with out_val = 0 and in_rdy = 0. This leaves one cycle of settling between domains for downstream pipelines, and limits each requester to at most p_slot_cycles-1 transfers per slot.
  - Undefined: guard = 0; every slot cycle is usable.

## Test plan
- Reset: hold reset_n = 0, then release -> sel = 0, cnt = 0, out_val = 0, in_rdy = 0; with en = 1 and all valid, requester 0 transfers in the first cycle.
- p_nreqs = 2, p_slot_cycles = 4, guard off, in_val = 2'b11, out_rdy = 1:
  - in_rdy = 01 for cycles 0-3 and 10 for cycles 4-7, repeating.
  - slot_last is high in cycles 3 and 7.
  - 4 transfers per requester per 8 cycles.
- Same stimulus with VC_TDM_GUARD_EN defined -> cycles 3 and 7 have out_val = 0 and in_rdy = 0; 3 transfers per slot.
- Isolation: in_val = 2'b10 held, out_rdy = 1 -> zero transfers in cycles 0-3, transfers in cycles 4-7; slot boundaries identical to the previous test.
- Backpressure and wrap:
  - p_nreqs = 3: out_rdy = 0 for cycles 2-5 -> no transfers in those cycles; sel sequence 0,0,0,0,1,1,1,1,2,2,2,2,0.
  - sel never shows 3.
- Disruption:
  - en dropped at cnt = 2 of requester 1's slot -> sel = 0 the next cycle.
  - Re-raising en starts requester 0's full slot.
  - reset_n pulsed low at cnt = 1 of any slot -> sel = 0 and in_rdy = 0 immediately, without waiting for a clock edge.
